// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI link: geometry, command opcodes,
// the two-byte opcode set and the 9-bit {dc,byte} word exchanged with the
// transmitter.
package oled_pkg;

  localparam int unsigned COLS_DEF  = 128;
  localparam int unsigned PAGES_DEF = 4;
  localparam int unsigned AW_DEF    = 10;
  localparam int unsigned COL_W     = 7;
  localparam int unsigned PAGE_W    = 3;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned BIT_CNT_W = 3;

  localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
  localparam logic [7:0] CMD_PAGE_BASE   = 8'hB0;
  localparam logic [7:0] CMD_COL_LO_BASE = 8'h00;
  localparam logic [7:0] CMD_COL_HI_BASE = 8'h10;

  // Opcodes followed by exactly one argument byte.
  localparam int unsigned N_TWO_BYTE = 9;
  localparam logic [N_TWO_BYTE-1:0][7:0] TWO_BYTE_OPS = {
    8'h81, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h20, 8'h8D
  };

  // One byte on the wire, qualified by DC (1 = data, 0 = command).
  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } oled_word_t;

  typedef enum logic {
    ST_CMD = 1'b0,
    ST_ARG = 1'b1
  } dec_state_t;

  function automatic logic is_two_byte(input logic [7:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(N_TWO_BYTE); i++) begin
      if (op == TWO_BYTE_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/oled_spi_shift.sv
// SPI byte deserialiser for the OLED link: SCK rise detect, MSB-first shift,
// bit counter and CS-high abort of partial bytes.
// Build option: OLED_RX_SYNC_EN adds a 2-flop synchroniser on every wire input.
// Ports:
//   clk_in_1MHz, rst_n_in          clock, async active-low reset
//   oled_cs/dc/sck/mosi            serial link inputs
//   byte_done_c, word_c            combinational: byte completes on this edge
//   rx_valid, rx_byte, rx_dc       registered one-cycle byte report
module oled_spi_shift
  import oled_pkg::*;
(
  input  logic       clk_in_1MHz,
  input  logic       rst_n_in,
  input  logic       oled_cs,
  input  logic       oled_dc,
  input  logic       oled_sck,
  input  logic       oled_mosi,
  output logic       byte_done_c,
  output oled_word_t word_c,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_dc
);

  logic cs_s, dc_s, sck_s, mosi_s;

`ifdef OLED_RX_SYNC_EN
  logic [1:0] cs_sync, dc_sync, sck_sync, mosi_sync;

  // Two-flop synchronisers; CS resets deasserted (high).
  always_ff @(posedge clk_in_1MHz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cs_sync   <= 2'b11;
      dc_sync   <= 2'b00;
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
    end else begin
      cs_sync   <= {cs_sync[0], oled_cs};
      dc_sync   <= {dc_sync[0], oled_dc};
      sck_sync  <= {sck_sync[0], oled_sck};
      mosi_sync <= {mosi_sync[0], oled_mosi};
    end
  end

  assign cs_s   = cs_sync[1];
  assign dc_s   = dc_sync[1];
  assign sck_s  = sck_sync[1];
  assign mosi_s = mosi_sync[1];
`else
  assign cs_s   = oled_cs;
  assign dc_s   = oled_dc;
  assign sck_s  = oled_sck;
  assign mosi_s = oled_mosi;
`endif

  logic                 sck_q;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [6:0]           shift_q;
  logic                 rise_c;

  assign rise_c      = sck_s & ~sck_q;
  assign byte_done_c = rise_c & ~cs_s & (bit_cnt == BIT_CNT_W'(7));
  // The 8th bit is taken straight from MOSI so the byte is ready on its edge.
  assign word_c      = '{dc: dc_s, data: {shift_q, mosi_s}};

  // Edge detect, shift register and bit counter.
  always_ff @(posedge clk_in_1MHz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sck_q   <= 1'b0;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      sck_q <= sck_s;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (rise_c) begin
        shift_q <= {shift_q[5:0], mosi_s};
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
    end
  end

  // Byte report, one cycle after the completing edge.
  always_ff @(posedge clk_in_1MHz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      rx_dc    <= 1'b0;
    end else begin
      rx_valid <= byte_done_c;
      if (byte_done_c) begin
        rx_byte <= word_c.data;
        rx_dc   <= word_c.dc;
      end
    end
  end

endmodule

// File: rtl/oled_spi_rx.sv
// Receive-side model of the 4-wire OLED SPI link. Deserialises bytes, decodes
// the page-addressing command subset and turns data bytes into GDDRAM write
// strobes at an auto-incrementing {page,col} cursor.
// Build option: OLED_RX_SYNC_EN synchronises the link inputs (adds 2 cycles).
// Ports:
//   clk_in_1MHz, rst_n_in          clock, async active-low reset
//   oled_cs/dc/sck/mosi            serial link inputs
//   rx_valid, rx_byte, rx_dc       byte log
//   wr_en, wr_addr, wr_data        GDDRAM write strobe
//   cur_page, cur_col              cursor
//   disp_on, cmd_cnt               display state, saturating command count
module oled_spi_rx
  import oled_pkg::*;
#(
  parameter int unsigned COLS  = COLS_DEF,
  parameter int unsigned PAGES = PAGES_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic              clk_in_1MHz,
  input  logic              rst_n_in,
  input  logic              oled_cs,
  input  logic              oled_dc,
  input  logic              oled_sck,
  input  logic              oled_mosi,
  output logic              rx_valid,
  output logic [7:0]        rx_byte,
  output logic              rx_dc,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [7:0]        wr_data,
  output logic [PAGE_W-1:0] cur_page,
  output logic [COL_W-1:0]  cur_col,
  output logic              disp_on,
  output logic [CNT_W-1:0]  cmd_cnt
);

  localparam logic [PAGE_W-1:0] PAGE_MAX = PAGE_W'(PAGES - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);

  logic       byte_done_c;
  oled_word_t word_c;

  oled_spi_shift u_shift (
    .clk_in_1MHz (clk_in_1MHz),
    .rst_n_in    (rst_n_in),
    .oled_cs     (oled_cs),
    .oled_dc     (oled_dc),
    .oled_sck    (oled_sck),
    .oled_mosi   (oled_mosi),
    .byte_done_c (byte_done_c),
    .word_c      (word_c),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .rx_dc       (rx_dc)
  );

  // Write strobe is registered on the completing edge so it lines up with rx_valid.
  always_ff @(posedge clk_in_1MHz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= byte_done_c & word_c.dc;
      if (byte_done_c & word_c.dc) begin
        wr_addr <= AW'({cur_page, cur_col});
        wr_data <= word_c.data;
      end
    end
  end

  dec_state_t              state_q, state_d;
  logic [PAGE_W-1:0]       page_d;
  logic [COL_W-1:0]        col_d;
  logic                    disp_d;
  logic [CNT_W-1:0]        cnt_d;

  // Decode state and cursor registers.
  always_ff @(posedge clk_in_1MHz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_CMD;
      cur_page <= '0;
      cur_col  <= '0;
      disp_on  <= 1'b0;
      cmd_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      cur_page <= page_d;
      cur_col  <= col_d;
      disp_on  <= disp_d;
      cmd_cnt  <= cnt_d;
    end
  end

  // Command decode and cursor advance, acting on the logged byte.
  always_comb begin
    state_d = state_q;
    page_d  = cur_page;
    col_d   = cur_col;
    disp_d  = disp_on;
    cnt_d   = cmd_cnt;
    if (rx_valid) begin
      if (rx_dc) begin
        // A data byte also terminates a pending argument wait.
        state_d = ST_CMD;
        col_d   = (cur_col == COL_LAST) ? '0 : cur_col + COL_W'(1);
      end else begin
        if (cmd_cnt != '1) cnt_d = cmd_cnt + CNT_W'(1);
        if (state_q == ST_ARG) begin
          state_d = ST_CMD;
        end else if (rx_byte[7:3] == CMD_PAGE_BASE[7:3]) begin
          page_d = (rx_byte[2:0] > PAGE_MAX) ? PAGE_MAX : rx_byte[2:0];
        end else if (rx_byte[7:4] == CMD_COL_LO_BASE[7:4]) begin
          col_d[3:0] = rx_byte[3:0];
        end else if (rx_byte[7:3] == CMD_COL_HI_BASE[7:3]) begin
          col_d[6:4] = rx_byte[2:0];
        end else if (rx_byte == CMD_DISP_OFF) begin
          disp_d = 1'b0;
        end else if (rx_byte == CMD_DISP_ON) begin
          disp_d = 1'b1;
        end else if (is_two_byte(rx_byte)) begin
          state_d = ST_ARG;
        end
      end
    end
  end

endmodule

// File: tb/tb_oled_spi_rx.sv
// Scoreboard bench for oled_spi_rx: a byte-level reference model queues the
// expected report for every complete byte; a monitor pops on rx_valid.
module tb_oled_spi_rx;

  localparam int COLS  = 128;
  localparam int PAGES = 4;

  logic        clk_in_1MHz = 1'b0;
  logic        rst_n_in    = 1'b0;
  logic        oled_cs     = 1'b1;
  logic        oled_dc     = 1'b0;
  logic        oled_sck    = 1'b0;
  logic        oled_mosi   = 1'b0;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_dc;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [2:0]  cur_page;
  logic [6:0]  cur_col;
  logic        disp_on;
  logic [15:0] cmd_cnt;

  oled_spi_rx dut (
    .clk_in_1MHz (clk_in_1MHz),
    .rst_n_in    (rst_n_in),
    .oled_cs     (oled_cs),
    .oled_dc     (oled_dc),
    .oled_sck    (oled_sck),
    .oled_mosi   (oled_mosi),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .rx_dc       (rx_dc),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .cur_page    (cur_page),
    .cur_col     (cur_col),
    .disp_on     (disp_on),
    .cmd_cnt     (cmd_cnt)
  );

  always #500 clk_in_1MHz = ~clk_in_1MHz;

  typedef struct {
    int b;
    int dc;
    int addr;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  int m_page = 0, m_col = 0, m_disp = 0, m_cnt = 0, m_arg = 0;

  int init_seq[29] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h1F, 8'hD3, 8'h00, 8'h40,
                       8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h02,
                       8'h81, 8'h8F, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA6, 8'h2E,
                       8'h21, 8'h00, 8'h7F, 8'hAF, 8'hA4};
  int two_byte[9] = '{8'h81, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h20, 8'h8D};

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_arg_op(input int b);
    foreach (two_byte[i]) if (two_byte[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Byte-level behaviour of the receiver, applied in send order.
  task automatic model_byte(input int dc, input int b);
    exp_t e;
    e.b = b; e.dc = dc; e.addr = m_page * COLS + m_col;
    exp_q.push_back(e);
    if (dc != 0) begin
      m_col = (m_col + 1) % COLS;
      m_arg = 0;
    end else begin
      if (m_cnt < 65535) m_cnt++;
      if (m_arg != 0) m_arg = 0;
      else if (b >= 8'hB0 && b <= 8'hB7) m_page = (b - 8'hB0 >= PAGES) ? PAGES - 1 : b - 8'hB0;
      else if (b <= 8'h0F) m_col = (m_col / 16) * 16 + b;
      else if (b >= 8'h10 && b <= 8'h17) m_col = (b - 8'h10) * 16 + (m_col % 16);
      else if (b == 8'hAE) m_disp = 0;
      else if (b == 8'hAF) m_disp = 1;
      else if (is_arg_op(b)) m_arg = 1;
    end
  endtask

  task automatic model_reset();
    m_page = 0; m_col = 0; m_disp = 0; m_cnt = 0; m_arg = 0;
  endtask

  // Drive nbits MSB-first within one CS frame, random 1..3-cycle SCK phases.
  task automatic send_bits(input int dc, input logic [7:0] b, input int nbits);
    @(negedge clk_in_1MHz);
    oled_cs = 1'b0;
    oled_dc = dc[0];
    for (int i = 7; i >= 8 - nbits; i--) begin
      oled_mosi = b[i];
      repeat ($urandom_range(1, 3)) @(negedge clk_in_1MHz);
      oled_sck = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk_in_1MHz);
      oled_sck = 1'b0;
    end
    @(negedge clk_in_1MHz);
    oled_cs = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk_in_1MHz);
  endtask

  task automatic send_byte(input int dc, input int b);
    model_byte(dc, b);
    send_bits(dc, 8'(b), 8);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk_in_1MHz);
      n++;
    end
    chk({name, "_drain_pending"}, exp_q.size(), 0);
    repeat (3) @(negedge clk_in_1MHz);
  endtask

  task automatic check_state(input string name);
    chk({name, "_page"}, int'(cur_page), m_page);
    chk({name, "_col"}, int'(cur_col), m_col);
    chk({name, "_disp"}, int'(disp_on), m_disp);
    chk({name, "_cmd_cnt"}, int'(cmd_cnt), m_cnt);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_rx_valid"}, int'(rx_valid), 0);
    chk({name, "_rx_byte"}, int'(rx_byte), 0);
    chk({name, "_rx_dc"}, int'(rx_dc), 0);
    chk({name, "_wr_en"}, int'(wr_en), 0);
    chk({name, "_wr_addr"}, int'(wr_addr), 0);
    chk({name, "_wr_data"}, int'(wr_data), 0);
    chk({name, "_page"}, int'(cur_page), 0);
    chk({name, "_col"}, int'(cur_col), 0);
    chk({name, "_disp"}, int'(disp_on), 0);
    chk({name, "_cmd_cnt"}, int'(cmd_cnt), 0);
  endtask

  // Pops one expectation per rx_valid pulse.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_in_1MHz);
      if (rst_n_in && rx_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rx_valid", int'(rx_byte), -1);
        end else begin
          e = exp_q.pop_front();
          chk("rx_byte", int'(rx_byte), e.b);
          chk("rx_dc", int'(rx_dc), e.dc);
          chk("wr_en", int'(wr_en), e.dc);
          if (e.dc != 0) begin
            chk("wr_addr", int'(wr_addr), e.addr);
            chk("wr_data", int'(wr_data), e.b);
          end
        end
      end else if (rst_n_in && wr_en) begin
        chk("wr_en_without_rx_valid", int'(wr_en), 0);
      end
    end
  endtask

  initial begin
    int cnt_before;
    fork
      monitor();
    join_none

    // Reset state
    #2300;
    check_all_zero("reset");
    @(negedge clk_in_1MHz);
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in_1MHz);

    // Init stream
    foreach (init_seq[i]) send_byte(0, init_seq[i]);
    drain("init");
    check_state("init");
    chk("init_cmd_cnt_29", int'(cmd_cnt), 29);
    chk("init_disp_on", int'(disp_on), 1);

    // Glyph row at page 0, col 1
    send_byte(0, 8'hB0); send_byte(0, 8'h10); send_byte(0, 8'h01);
    send_byte(1, 8'h00); send_byte(1, 8'h20); send_byte(1, 8'h54);
    send_byte(1, 8'h54); send_byte(1, 8'h54); send_byte(1, 8'h78);
    drain("glyph");
    check_state("glyph");
    chk("glyph_col_7", int'(cur_col), 7);

    // Column wrap at page 3
    send_byte(0, 8'hB3); send_byte(0, 8'h17); send_byte(0, 8'h0F);
    repeat (3) send_byte(1, 8'hAA);
    drain("wrap");
    check_state("wrap");
    chk("wrap_page_3", int'(cur_page), 3);

    // Page clamp
    send_byte(0, 8'hB6);
    drain("clamp");
    chk("clamp_page", int'(cur_page), 3);

    // Partial byte aborted by CS, and a rise while CS high
    send_bits(0, 8'hFF, 5);
    @(negedge clk_in_1MHz); oled_sck = 1'b1;
    @(negedge clk_in_1MHz); oled_sck = 1'b0;
    @(negedge clk_in_1MHz);
    send_byte(0, 8'h3C);
    drain("abort");
    check_state("abort");
    chk("abort_rx_byte", int'(rx_byte), 8'h3C);

    // Data byte while waiting for an argument
    cnt_before = m_cnt;
    send_byte(0, 8'h81); send_byte(1, 8'h55);
    drain("argdata");
    check_state("argdata");
    chk("argdata_cnt_delta", int'(cmd_cnt) - cnt_before, 1);
    chk("argdata_wr_data", int'(wr_data), 8'h55);
    send_byte(0, 8'hAE);
    drain("argdata_cmd");
    chk("argdata_back_in_cmd", int'(disp_on), 0);

    // Randomised traffic
    for (int i = 0; i < 120; i++) begin
      int dc, b;
      dc = int'($urandom_range(0, 1));
      b  = int'($urandom_range(0, 255));
      send_byte(dc, b);
    end
    drain("rand");
    check_state("rand");

    // Reset mid-byte
    send_bits(1, 8'hC3, 4);
    oled_cs = 1'b0;
    oled_sck = 1'b1;
    @(negedge clk_in_1MHz);
    rst_n_in = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    oled_cs = 1'b1;
    oled_sck = 1'b0;
    repeat (2) @(negedge clk_in_1MHz);
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in_1MHz);
    send_byte(0, 8'hAF);
    drain("postreset");
    check_state("postreset");
    chk("postreset_disp_on", int'(disp_on), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
